// File: rtl/halton_pkg.sv
// Shared types and constants for the 2-D Halton (bases 2,3) point path.
package halton_pkg;

  localparam int HALTON_W = 32;

  // Generator fixed-point scale exponents, kept here so producer and consumer agree.
  localparam int SCALE_0 = 11;
  localparam int SCALE_1 = 7;

  typedef struct packed {
    logic [HALTON_W-1:0] index;
    logic [HALTON_W-1:0] data_1;
    logic [HALTON_W-1:0] data_0;
  } halton_point_t;

endpackage

// File: rtl/halton_point_buffer_if.sv
// Generator-side and consumer-side signals of the Halton point buffer.
interface halton_point_buffer_if #(
  parameter int DEPTH = 8
);

  logic                                gen_valid;
  logic [halton_pkg::HALTON_W-1:0]     gen_data_0;
  logic [halton_pkg::HALTON_W-1:0]     gen_data_1;
  logic                                gen_pop_enable;
  logic                                flush;
  logic                                m_valid;
  logic                                m_ready;
  logic [halton_pkg::HALTON_W-1:0]     m_data_0;
  logic [halton_pkg::HALTON_W-1:0]     m_data_1;
  logic [halton_pkg::HALTON_W-1:0]     m_index;
  logic [$clog2(DEPTH):0]              level;
  logic                                overflow;

  modport master (
    output gen_valid, gen_data_0, gen_data_1, flush, m_ready,
    input  gen_pop_enable, m_valid, m_data_0, m_data_1, m_index, level, overflow
  );

  modport slave (
    input  gen_valid, gen_data_0, gen_data_1, flush, m_ready,
    output gen_pop_enable, m_valid, m_data_0, m_data_1, m_index, level, overflow
  );

endinterface

// File: rtl/halton_sync_fifo.sv
// Generic synchronous FIFO with flush; the caller guarantees no push when full
// without a same-cycle pop and no pop when empty.
module halton_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + LVL_W'(push_i) - LVL_W'(pop_i);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the head is only meaningful while level_o != 0.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/halton_point_buffer.sv
// Captures Halton points with their sequence index, buffers them, and throttles
// the generator so in-flight points still find room under backpressure.
module halton_point_buffer
  import halton_pkg::*;
#(
  parameter int                  DEPTH       = 8,
  parameter int                  HEADROOM    = 2,
  parameter logic [HALTON_W-1:0] INDEX_START = 32'd1
) (
  input logic                  clk,
  input logic                  rst,
  halton_point_buffer_if.slave pb
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL     = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] THROTTLE_LVL = LVL_W'(DEPTH - HEADROOM);

  halton_point_t       wr_point_s;
  halton_point_t       head_s;
  logic [LVL_W-1:0]    level_s;
  logic [LVL_W-1:0]    level_next_s;
  logic                valid_s;
  logic                full_s;
  logic                push_s;
  logic                pop_s;
  logic                drop_s;
  logic                pop_en_d;
  logic [HALTON_W-1:0] index_q;
  logic                overflow_q;
  logic                pop_en_q;

  // Handshake decode: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    valid_s      = (level_s != {LVL_W{1'b0}});
    full_s       = (level_s == FULL_LVL);
    pop_s        = valid_s && pb.m_ready && !pb.flush;
    push_s       = pb.gen_valid && !pb.flush && (!full_s || pop_s);
    drop_s       = pb.gen_valid && !pb.flush && full_s && !pop_s;
    wr_point_s   = '{index: index_q, data_1: pb.gen_data_1, data_0: pb.gen_data_0};
    level_next_s = {LVL_W{1'b0}};
    if (pb.flush) begin
      level_next_s = {LVL_W{1'b0}};
    end else begin
      level_next_s = level_s + LVL_W'(push_s) - LVL_W'(pop_s);
    end
    pop_en_d = !pb.flush && (level_next_s <= THROTTLE_LVL);
  end

  halton_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (halton_point_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (pb.flush),
    .wdata_i (wr_point_s),
    .rdata_o (head_s),
    .level_o (level_s)
  );

  // Index counts every strobe, dropped or flushed, so gaps in m_index expose loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q    <= INDEX_START;
      overflow_q <= 1'b0;
      pop_en_q   <= 1'b0;
    end else begin
      if (pb.gen_valid) begin
        index_q <= index_q + 32'd1;
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
      pop_en_q <= pop_en_d;
    end
  end

  assign pb.gen_pop_enable = pop_en_q;
  assign pb.m_valid        = valid_s;
  assign pb.m_data_0       = valid_s ? head_s.data_0 : {HALTON_W{1'b0}};
  assign pb.m_data_1       = valid_s ? head_s.data_1 : {HALTON_W{1'b0}};
  assign pb.m_index        = valid_s ? head_s.index  : {HALTON_W{1'b0}};
  assign pb.level          = level_s;
  assign pb.overflow       = overflow_q;

endmodule
